// File: rtl/alu_pkg.sv
// Shared constants for the ALU result stages.
//   ALU_WIDTH : default datapath width
//   FLAG_W    : width of the condition-flag vector {N,Z,C,V}
//   FLAG_*    : bit positions of each flag inside that vector
package alu_pkg;

  localparam int unsigned ALU_WIDTH = 32;
  localparam int unsigned FLAG_W    = 4;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  typedef logic [FLAG_W-1:0] flags_t;

endpackage

// File: rtl/alu_flag_gen.sv
// Combinational N/Z/C/V generator for an ADD result.
// Ports:
//   in1, in2   : operands presented to the adder
//   add_result : adder output for in1 + in2
//   flags      : {N,Z,C,V} at bit positions FLAG_N..FLAG_V
module alu_flag_gen
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_WIDTH
) (
  input  logic [WIDTH-1:0]  in1,
  input  logic [WIDTH-1:0]  in2,
  input  logic [WIDTH-1:0]  add_result,
  output logic [FLAG_W-1:0] flags
);

  // Only the sign bit of in2 matters for overflow detection.
  logic unused_in2_low;
  assign unused_in2_low = ^in2[WIDTH-2:0];

  always_comb begin
    flags         = '0;
    flags[FLAG_N] = add_result[WIDTH-1];
    flags[FLAG_Z] = (add_result == '0);
    // Unsigned wrap-around implies a carry out of the adder.
    flags[FLAG_C] = (add_result < in1);
    // Like-signed operands producing a differently-signed result.
    flags[FLAG_V] = (in1[WIDTH-1] == in2[WIDTH-1]) &&
                    (add_result[WIDTH-1] != in1[WIDTH-1]);
  end

endmodule

// File: rtl/alu_result_stage.sv
// Registered result stage behind the 32-bit ADD unit.
// Captures each accepted ADD result with its N/Z/C/V flags into a small FIFO
// drained by the consumer under valid/ready. Also tracks a sticky overflow
// flag and a wrapping count of accepted results.
// Ports:
//   clk, rst_n            : clock, synchronous active-low reset
//   in1, in2, add_result  : operands and ADD output
//   in_valid / in_ready   : producer handshake (in_ready from registered count only)
//   out_valid / out_ready : consumer handshake
//   out_result, out_flags : head entry, read straight from storage
//   sticky_v, clr_sticky  : sticky overflow flag and its clear
//   acc_count             : number of accepted entries, wraps
module alu_result_stage
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_WIDTH,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WIDTH-1:0]  in1,
  input  logic [WIDTH-1:0]  in2,
  input  logic [WIDTH-1:0]  add_result,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_result,
  output logic [FLAG_W-1:0] out_flags,
  output logic              sticky_v,
  input  logic              clr_sticky,
  output logic [CNT_W-1:0]  acc_count
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0]  res_mem_q [DEPTH];
  logic [FLAG_W-1:0] flg_mem_q [DEPTH];

  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             sticky_q, sticky_d;
  logic [CNT_W-1:0] acc_q, acc_d;

  logic [FLAG_W-1:0] new_flags;
  logic              push, pop;

  alu_flag_gen #(
    .WIDTH (WIDTH)
  ) u_flag_gen (
    .in1        (in1),
    .in2        (in2),
    .add_result (add_result),
    .flags      (new_flags)
  );

  assign in_ready   = (count_q < CntW'(DEPTH));
  assign out_valid  = (count_q != '0);
  assign out_result = res_mem_q[rd_ptr_q];
  assign out_flags  = flg_mem_q[rd_ptr_q];
  assign sticky_v   = sticky_q;
  assign acc_count  = acc_q;

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    sticky_d = sticky_q;
    acc_d    = acc_q;

    if (push) begin
      wr_ptr_d = (wr_ptr_q == PtrW'(DEPTH - 1)) ? '0 : wr_ptr_q + PtrW'(1);
      acc_d    = acc_q + CNT_W'(1);
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PtrW'(DEPTH - 1)) ? '0 : rd_ptr_q + PtrW'(1);
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase

    // Set beats clear when both land in the same cycle.
    if (push && new_flags[FLAG_V]) begin
      sticky_d = 1'b1;
    end else if (clr_sticky) begin
      sticky_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      sticky_q <= 1'b0;
      acc_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      sticky_q <= sticky_d;
      acc_q    <= acc_d;
    end
  end

  // Storage is cleared on reset so the head reads as zero, never X.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        res_mem_q[i] <= '0;
        flg_mem_q[i] <= '0;
      end
    end else if (push) begin
      res_mem_q[wr_ptr_q] <= add_result;
      flg_mem_q[wr_ptr_q] <= new_flags;
    end
  end

endmodule

// File: tb/tb_alu_result_stage.sv
module tb_alu_result_stage;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] in1, in2, add_result;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] out_result;
  logic [3:0]  out_flags;
  logic        sticky_v, clr_sticky;
  logic [15:0] acc_count;

  alu_result_stage dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in1        (in1),
    .in2        (in2),
    .add_result (add_result),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_flags  (out_flags),
    .sticky_v   (sticky_v),
    .clr_sticky (clr_sticky),
    .acc_count  (acc_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] r;
    logic [3:0]  f;
  } ent_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    logic [3:0]  f;
  } vec_t;

  // Reference model state.
  ent_t        mq[$];
  logic        m_sticky;
  logic [15:0] m_acc;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Flags from arithmetic meaning: sign, zero, unsigned carry, signed range overflow.
  function automatic logic [3:0] ref_flags(input logic [31:0] a, input logic [31:0] b,
                                           input logic [31:0] r);
    longint sa, sb, ssum;
    logic n, z, c, v;
    sa   = longint'($signed(a));
    sb   = longint'($signed(b));
    ssum = sa + sb;
    n = r[31];
    z = (r == 32'd0);
    c = (r < a);
    v = (ssum > 64'sd2147483647) || (ssum < -64'sd2147483648);
    return {n, z, c, v};
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ":out_valid"}, 64'(out_valid), 64'(mq.size() != 0));
    chk({tag, ":in_ready"}, 64'(in_ready), 64'(mq.size() < DEPTH));
    chk({tag, ":sticky_v"}, 64'(sticky_v), 64'(m_sticky));
    chk({tag, ":acc_count"}, 64'(acc_count), 64'(m_acc));
    if (mq.size() != 0) begin
      chk({tag, ":out_result"}, 64'(out_result), 64'(mq[0].r));
      chk({tag, ":out_flags"}, 64'(out_flags), 64'(mq[0].f));
    end
  endtask

  // Drive one cycle, advance the model across the edge, then compare.
  task automatic cyc(input string tag, input logic v, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] r, input logic ordy,
                     input logic clr, input logic rst);
    bit   do_push, do_pop;
    ent_t e;
    in_valid   = v;
    in1        = a;
    in2        = b;
    add_result = r;
    out_ready  = ordy;
    clr_sticky = clr;
    rst_n      = ~rst;
    do_push = v && (mq.size() < DEPTH);
    do_pop  = ordy && (mq.size() != 0);
    e.r = r;
    e.f = ref_flags(a, b, r);
    @(posedge clk);
    if (rst) begin
      mq.delete();
      m_sticky = 1'b0;
      m_acc    = 16'd0;
    end else begin
      if (do_pop) void'(mq.pop_front());
      if (do_push) mq.push_back(e);
      if (do_push && e.f[0]) m_sticky = 1'b1;
      else if (clr) m_sticky = 1'b0;
      if (do_push) m_acc = m_acc + 16'd1;
    end
    #1;
    check_all(tag);
  endtask

  task automatic idle(input string tag, input logic ordy, input logic clr);
    cyc(tag, 1'b0, 32'd0, 32'd0, 32'd0, ordy, clr, 1'b0);
  endtask

  task automatic do_reset();
    cyc("reset", 1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'(($urandom_range(0, 15)));
      default: return $urandom;
    endcase
  endfunction

  vec_t tbl[6];

  initial begin
    m_sticky = 1'b0;
    m_acc    = 16'd0;

    tbl[0] = '{32'd2,         32'd3,         32'd5,         4'b0000};
    tbl[1] = '{32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 4'b1001};
    tbl[2] = '{32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 4'b0110};
    tbl[3] = '{32'd0,         32'd0,         32'd0,         4'b0100};
    tbl[4] = '{32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 4'b0111};
    tbl[5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 4'b1010};

    do_reset();
    do_reset();
    chk("rst:out_valid", 64'(out_valid), 64'd0);
    chk("rst:in_ready", 64'(in_ready), 64'd1);
    chk("rst:out_result", 64'(out_result), 64'd0);
    chk("rst:out_flags", 64'(out_flags), 64'd0);
    chk("rst:sticky_v", 64'(sticky_v), 64'd0);
    chk("rst:acc_count", 64'(acc_count), 64'd0);

    // Table: push into empty FIFO, head visible next cycle, then drain.
    for (int i = 0; i < 6; i++) begin
      logic sticky_before;
      sticky_before = sticky_v;
      cyc("tbl_push", 1'b1, tbl[i].a, tbl[i].b, tbl[i].r, 1'b1, 1'b0, 1'b0);
      chk($sformatf("tbl%0d:valid", i), 64'(out_valid), 64'd1);
      chk($sformatf("tbl%0d:result", i), 64'(out_result), 64'(tbl[i].r));
      chk($sformatf("tbl%0d:flags", i), 64'(out_flags), 64'(tbl[i].f));
      chk($sformatf("tbl%0d:sticky", i), 64'(sticky_v), 64'(sticky_before | tbl[i].f[0]));
      chk($sformatf("tbl%0d:acc", i), 64'(acc_count), 64'(i + 1));
      idle("tbl_pop", 1'b1, 1'b0);
    end

    // Sticky clear with no push; then set-vs-clear in the same cycle.
    idle("clr", 1'b0, 1'b1);
    chk("clr:sticky_v", 64'(sticky_v), 64'd0);
    cyc("setclr", 1'b1, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    chk("setclr:sticky_v", 64'(sticky_v), 64'd1);
    idle("setclr_pop", 1'b1, 1'b1);
    chk("setclr2:sticky_v", 64'(sticky_v), 64'd0);

    // Backpressure: two pushes fill the FIFO, third is held by the source.
    do_reset();
    cyc("bp1", 1'b1, 32'd1, 32'd3, 32'd4, 1'b0, 1'b0, 1'b0);
    cyc("bp2", 1'b1, 32'd6, 32'd2, 32'd8, 1'b0, 1'b0, 1'b0);
    chk("bp:in_ready_full", 64'(in_ready), 64'd0);
    cyc("bp3", 1'b1, 32'd5, 32'd9, 32'd14, 1'b0, 1'b0, 1'b0);
    chk("bp:held_head", 64'(out_result), 64'd4);
    chk("bp:held_acc", 64'(acc_count), 64'd2);
    // Full with pop: no push this edge.
    cyc("bp4", 1'b1, 32'd5, 32'd9, 32'd14, 1'b1, 1'b0, 1'b0);
    chk("bp:pop_order1", 64'(out_result), 64'd8);
    chk("bp:no_push_full", 64'(acc_count), 64'd2);
    cyc("bp5", 1'b1, 32'd5, 32'd9, 32'd14, 1'b1, 1'b0, 1'b0);
    chk("bp:pop_order2", 64'(out_result), 64'd14);
    idle("bp6", 1'b1, 1'b0);
    chk("bp:empty", 64'(out_valid), 64'd0);
    chk("bp:acc_final", 64'(acc_count), 64'd3);

    // Simultaneous push/pop at count=1.
    cyc("pp1", 1'b1, 32'd10, 32'd10, 32'd20, 1'b0, 1'b0, 1'b0);
    chk("pp:head20", 64'(out_result), 64'd20);
    cyc("pp2", 1'b1, 32'd10, 32'd6, 32'd16, 1'b1, 1'b0, 1'b0);
    chk("pp:head16", 64'(out_result), 64'd16);
    chk("pp:in_ready", 64'(in_ready), 64'd1);
    idle("pp3", 1'b1, 1'b0);
    chk("pp:count_was1", 64'(out_valid), 64'd0);

    // Reset mid-operation with two queued entries and sticky set.
    cyc("mr1", 1'b1, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 1'b0, 1'b0, 1'b0);
    cyc("mr2", 1'b1, 32'd1, 32'd1, 32'd2, 1'b0, 1'b0, 1'b0);
    chk("mr:sticky_pre", 64'(sticky_v), 64'd1);
    cyc("mr_rst", 1'b1, 32'd3, 32'd4, 32'd7, 1'b1, 1'b0, 1'b1);
    chk("mr:out_valid", 64'(out_valid), 64'd0);
    chk("mr:in_ready", 64'(in_ready), 64'd1);
    chk("mr:sticky_v", 64'(sticky_v), 64'd0);
    chk("mr:acc_count", 64'(acc_count), 64'd0);
    chk("mr:out_result", 64'(out_result), 64'd0);
    chk("mr:out_flags", 64'(out_flags), 64'd0);

    // Randomised traffic against the model.
    for (int i = 0; i < 500; i++) begin
      logic [31:0] a, b;
      a = pick();
      b = pick();
      cyc("rand", ($urandom_range(0, 3) != 0), a, b, a + b, ($urandom_range(0, 2) != 0),
          ($urandom_range(0, 7) == 0), 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
